// File: rtl/sha_fold_core.sv
// sha_fold_core: folded SHA-256 compression core.
//
// The core takes one 512-bit message block, a 256-bit chaining value and an
// opaque tag. It runs the 64 SHA-256 rounds through UNROLL combinationally
// chained round instances per clock, adds the chaining value back in, and
// returns the new chaining value together with the unchanged tag.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   job offered on in_M / in_H / in_tag
//   in_ready   core accepts a job on this cycle's edge when in_valid is high
//   in_M       message block, W0 = in_M[511:480] ... W15 = in_M[31:0]
//   in_H       chaining value, H0 = in_H[255:224] ... H7 = in_H[31:0]
//   in_tag     opaque tag, returned unchanged with the result
//   out_valid  result available on out_H / out_tag
//   out_ready  consumer takes the result on this cycle's edge
//   out_H      in_H + compress(in_M), same word order as in_H
//   out_tag    tag of the job that produced out_H
//
// Parameters:
//   UNROLL     rounds per clock: 1, 2, 4, 8 or 16
//   TAG_W      tag width
module sha_fold_core #(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_M,
    input  logic [255:0]     in_H,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     out_H,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
            $error("sha_fold_core: UNROLL must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Round constant ROM, element 0 first.
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [6:0] RND_STEP = 7'(UNROLL);
    localparam logic [6:0] RND_LAST = 7'd64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [6:0]       rnd;
    logic [6:0]       rnd_inc;
    logic             accept;

    logic [511:0]     win;        // schedule window, word 0 in the top 32 bits
    logic [511:0]     win_nxt;
    logic [255:0]     work;       // working variables a..h, a in the top 32 bits
    logic [255:0]     work_nxt;
    logic [255:0]     h_save;
    logic [255:0]     final_sum;
    logic [TAG_W-1:0] tag_r;

    // ------------------------------------------------------------------
    // SHA-256 primitive functions
    // ------------------------------------------------------------------
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] choose(input logic [31:0] e, input logic [31:0] f,
                                           input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // One compression round over the packed a..h vector.
    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_sigma1(e) + choose(e, f, g) + k + w;
        t2 = big_sigma0(a) + majority(a, b, c);
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Next schedule word from the current window: s1(w14) + w9 + s0(w1) + w0.
    function automatic logic [31:0] sched_word(input logic [511:0] wnd);
        return small_sigma1(wnd[63:32]) + wnd[223:192] + small_sigma0(wnd[479:448]) + wnd[511:480];
    endfunction

    // ------------------------------------------------------------------
    // Control: handshake and state sequencing
    // ------------------------------------------------------------------
    assign rnd_inc = rnd + RND_STEP;
    assign accept  = in_ready && in_valid;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ROUND;
            end
            ROUND: begin
                if (rnd_inc == RND_LAST) state_nxt = FINAL;
            end
            FINAL: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // A new job can be taken on the same edge that hands the
                // result over, which removes the IDLE bubble.
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? ROUND : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: UNROLL rounds chained per clock
    // ------------------------------------------------------------------
    always_comb begin
        work_nxt = work;
        win_nxt  = win;
        for (int u = 0; u < UNROLL; u++) begin
            work_nxt = sha_round(work_nxt, K[rnd[5:0] + 6'(u)], win_nxt[511:480]);
            win_nxt  = {win_nxt[479:0], sched_word(win_nxt)};
        end
    end

    always_comb begin
        final_sum = '0;
        for (int j = 0; j < 8; j++) begin
            final_sum[j*32 +: 32] = h_save[j*32 +: 32] + work[j*32 +: 32];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rnd     <= '0;
            out_H   <= '0;
            out_tag <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rnd <= '0;
            end else if (state == ROUND) begin
                rnd <= rnd_inc;
            end
            if (state == FINAL) begin
                out_H   <= final_sum;
                out_tag <= tag_r;
            end
        end
    end

    // Job payload registers carry no reset: they are only read after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            win    <= in_M;
            work   <= in_H;
            h_save <= in_H;
            tag_r  <= in_tag;
        end else if (state == ROUND) begin
            win    <= win_nxt;
            work   <= work_nxt;
        end
    end

endmodule

// File: tb/tb_sha_fold_core.sv
// tb_sha_fold_core: self-checking bench for sha_fold_core.
// Five instances (UNROLL = 1, 2, 4, 8, 16) share clock and reset; each is
// driven through its own slot of the per-instance signal arrays.
module tb_sha_fold_core;

    localparam int NI = 5;

    localparam logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC_M  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_D  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] EMP_M  = {32'h80000000, 480'h0};
    localparam logic [255:0] EMP_D  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         reset;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [511:0] in_M      [NI];
    logic [255:0] in_H      [NI];
    logic [31:0]  in_tag    [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [255:0] out_H     [NI];
    logic [31:0]  out_tag   [NI];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int           inst;
        logic [511:0] m;
        logic [255:0] h;
        logic [31:0]  tag;
        logic [255:0] dig;
        int           lat;
    } vec_t;

    vec_t vt [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha_fold_core #(.UNROLL(1 << g), .TAG_W(32)) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_M      (in_M[g]),
            .in_H      (in_H[g]),
            .in_tag    (in_tag[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_H     (out_H[g]),
            .out_tag   (out_tag[g])
        );
    end

    // Behavioural SHA-256 compression: full 64-word expansion, then rounds.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_ref(input logic [511:0] m, input logic [255:0] hin);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  s0, s1, t1, t2, ch, mj;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1 = v[7] + s1 + ch + KT[t] + w[t];
            s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2 = s0 + mj;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        res = '0;
        for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
        return res;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r = {r[479:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a job for one edge; the inputs are scrambled afterwards so any
    // late sampling by the DUT shows up in the digest.
    task automatic start_job(input int i, input logic [511:0] m, input logic [255:0] h,
                             input logic [31:0] tag, input string nm);
        chk({nm, " in_ready before accept"}, 256'(in_ready[i]), 256'(1));
        in_M[i]     = m;
        in_H[i]     = h;
        in_tag[i]   = tag;
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
        in_M[i]     = ~m;
        in_H[i]     = ~h;
        in_tag[i]   = ~tag;
    endtask

    task automatic wait_out(input int i, output int lat);
        lat = 0;
        while (!out_valid[i] && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_result(input int i, input string nm);
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
        chk({nm, " out_valid after handshake"}, 256'(out_valid[i]), 256'(0));
    endtask

    task automatic run_job(input int i, input logic [511:0] m, input logic [255:0] h,
                           input logic [31:0] tag, input logic [255:0] exp_d,
                           input int exp_lat, input int hold, input string nm);
        int lat;
        out_ready[i] = 1'b0;
        start_job(i, m, h, tag, nm);
        wait_out(i, lat);
        chk({nm, " latency"}, 256'(lat), 256'(exp_lat));
        chk({nm, " digest"}, out_H[i], exp_d);
        chk({nm, " tag"}, 256'(out_tag[i]), 256'(tag));
        repeat (hold) tick();
        if (hold > 0) chk({nm, " digest after hold"}, out_H[i], exp_d);
        take_result(i, nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat;
        logic [511:0] m;
        logic [511:0] bm [4];
        logic [255:0] h;
        logic [255:0] held;
        logic [31:0]  tag;

        vt[0] = '{0, ABC_M, IV, 32'hdeadbeef, ABC_D, 65};
        vt[1] = '{0, EMP_M, IV, 32'h00000001, EMP_D, 65};
        vt[2] = '{1, EMP_M, IV, 32'h00000002, EMP_D, 33};
        vt[3] = '{2, EMP_M, IV, 32'h00000003, EMP_D, 17};
        vt[4] = '{3, EMP_M, IV, 32'h00000004, EMP_D, 9};
        vt[5] = '{4, EMP_M, IV, 32'h00000005, EMP_D, 5};

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_M[i]      = '0;
            in_H[i]      = '0;
            in_tag[i]    = '0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset out_valid u%0d", i), 256'(out_valid[i]), 256'(0));
            chk($sformatf("reset out_H u%0d", i), out_H[i], 256'(0));
            chk($sformatf("reset out_tag u%0d", i), 256'(out_tag[i]), 256'(0));
            chk($sformatf("reset in_ready u%0d", i), 256'(in_ready[i]), 256'(1));
        end

        chk("model abc", sha_ref(ABC_M, IV), ABC_D);
        chk("model empty", sha_ref(EMP_M, IV), EMP_D);

        // Known-answer vectors.
        for (int k = 0; k < 6; k++) begin
            run_job(vt[k].inst, vt[k].m, vt[k].h, vt[k].tag, vt[k].dig, vt[k].lat, 0,
                    $sformatf("vec%0d", k));
        end

        // Random jobs against the reference model, random consumer delay.
        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < 3; r++) begin
                m   = rand512();
                h   = rand256();
                tag = $urandom();
                run_job(i, m, h, tag, sha_ref(m, h), 64 / (1 << i) + 1,
                        int'($urandom_range(0, 3)), $sformatf("rand u%0d #%0d", i, r));
            end
        end

        // Backpressure: result held for 20 cycles while a new job is offered.
        m   = rand512();
        tag = 32'h0badcafe;
        start_job(4, m, IV, tag, "bp");
        wait_out(4, lat);
        chk("bp latency", 256'(lat), 256'(5));
        held = out_H[4];
        chk("bp digest", held, sha_ref(m, IV));
        in_M[4]     = rand512();
        in_H[4]     = IV;
        in_tag[4]   = 32'h11111111;
        in_valid[4] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("bp out_valid c%0d", c), 256'(out_valid[4]), 256'(1));
            chk($sformatf("bp out_H c%0d", c), out_H[4], held);
            chk($sformatf("bp out_tag c%0d", c), 256'(out_tag[4]), 256'(tag));
            chk($sformatf("bp in_ready c%0d", c), 256'(in_ready[4]), 256'(0));
        end
        in_valid[4] = 1'b0;
        take_result(4, "bp");
        repeat (3) tick();
        chk("bp single handshake", 256'(out_valid[4]), 256'(0));
        chk("bp in_ready after", 256'(in_ready[4]), 256'(1));

        // Reset in the middle of the rounds.
        start_job(0, ABC_M, IV, 32'hdeadbeef, "rst");
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst out_valid", 256'(out_valid[0]), 256'(0));
        chk("rst out_H", out_H[0], 256'(0));
        chk("rst out_tag", 256'(out_tag[0]), 256'(0));
        chk("rst in_ready", 256'(in_ready[0]), 256'(1));
        run_job(0, ABC_M, IV, 32'hdeadbeef, ABC_D, 65, 0, "abc after rst");

        // in_valid during ROUND must be ignored.
        m = rand512();
        start_job(0, m, IV, 32'h0000abcd, "busy");
        repeat (10) tick();
        in_M[0]     = rand512();
        in_H[0]     = rand256();
        in_tag[0]   = 32'h55555555;
        in_valid[0] = 1'b1;
        chk("busy in_ready", 256'(in_ready[0]), 256'(0));
        tick();
        in_valid[0] = 1'b0;
        wait_out(0, lat);
        chk("busy latency", 256'(lat + 11), 256'(65));
        chk("busy digest", out_H[0], sha_ref(m, IV));
        chk("busy tag", 256'(out_tag[0]), 256'(32'h0000abcd));
        take_result(0, "busy");

        // Back-to-back jobs at UNROLL=4 with in_valid and out_ready held high.
        begin
            int nxt;
            int got;
            int cyc;
            int last;
            logic acc;
            nxt  = 0;
            got  = 0;
            cyc  = 0;
            last = 0;
            for (int k = 0; k < 4; k++) bm[k] = rand512();
            in_M[2]      = bm[0];
            in_H[2]      = IV;
            in_tag[2]    = 32'd1;
            in_valid[2]  = 1'b1;
            out_ready[2] = 1'b1;
            while (got < 4 && cyc < 400) begin
                acc = in_ready[2] && in_valid[2];
                if (out_valid[2]) begin
                    chk($sformatf("b2b tag #%0d", got), 256'(out_tag[2]), 256'(got + 1));
                    chk($sformatf("b2b digest #%0d", got), out_H[2], sha_ref(bm[got], IV));
                    if (got > 0) chk($sformatf("b2b spacing #%0d", got), 256'(cyc - last), 256'(18));
                    last = cyc;
                    got++;
                end
                tick();
                cyc++;
                if (acc) begin
                    nxt++;
                    if (nxt < 4) begin
                        in_M[2]   = bm[nxt];
                        in_tag[2] = 32'(nxt + 1);
                    end else begin
                        in_valid[2] = 1'b0;
                    end
                end
            end
            chk("b2b results received", 256'(got), 256'(4));
            tick();
            out_ready[2] = 1'b0;
            in_valid[2]  = 1'b0;
            chk("b2b idle after", 256'(in_ready[2]), 256'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
